// File: rtl/udp_receive.sv
// GMII-side UDP/IPv4 receiver: strips preamble/SFD and the Ethernet, IPv4 and UDP headers,
// filters on local MAC/IP/port and streams the UDP payload bytes out.
module udp_receive #(
  parameter bit ACCEPT_BROADCAST = 1'b1,
  parameter int MAX_PAYLOAD      = 1472
) (
  input  logic        clk_125m,
  input  logic        reset_n,
  input  logic [47:0] local_mac,
  input  logic [31:0] local_ip,
  input  logic [15:0] local_port,
  input  logic [7:0]  gmii_rxd,
  input  logic        gmii_rx_dv,
  output logic [7:0]  rx_data,
  output logic        rx_data_valid,
  output logic        rx_done,
  output logic        rx_error,
  output logic [15:0] rx_byte_num,
  output logic [31:0] rx_src_ip,
  output logic [15:0] rx_src_port
);

  localparam logic [15:0] MAX_P = 16'(MAX_PAYLOAD);

  typedef enum logic [2:0] {
    IDLE, PREAMBLE, ETH_HEAD, IP_HEAD, UDP_HEAD, RX_DATA, DROP
  } state_t;

  state_t      state_reg, state_next;
  logic [15:0] cnt_reg, cnt_next;
  logic        uc_ok_reg, uc_ok_next;
  logic        bc_ok_reg, bc_ok_next;
  logic [3:0]  ihl_reg, ihl_next;
  logic [31:0] ip_hold_reg, ip_hold_next;
  logic [15:0] port_hold_reg, port_hold_next;
  logic [15:0] udp_len_reg, udp_len_next;
  logic [7:0]  rx_data_reg, rx_data_next;
  logic        rx_valid_reg, rx_valid_next;
  logic        rx_done_reg, rx_done_next;
  logic        rx_error_reg, rx_error_next;
  logic [15:0] byte_num_reg, byte_num_next;
  logic [31:0] src_ip_reg, src_ip_next;
  logic [15:0] src_port_reg, src_port_next;

  logic [7:0]  mac_bytes  [6];
  logic [7:0]  ip_bytes   [4];
  logic [7:0]  port_bytes [2];
  logic [15:0] payload_len;
  logic [15:0] ip_end;
  logic        uc_hit, bc_hit, hdr_bad;

  // Wire-order byte views of the local addresses (most significant byte first).
  genvar gi;
  generate
    for (gi = 0; gi < 6; gi++) begin : g_mac
      assign mac_bytes[gi] = local_mac[47-8*gi -: 8];
    end
    for (gi = 0; gi < 4; gi++) begin : g_ip
      assign ip_bytes[gi] = local_ip[31-8*gi -: 8];
    end
    for (gi = 0; gi < 2; gi++) begin : g_port
      assign port_bytes[gi] = local_port[15-8*gi -: 8];
    end
  endgenerate

  assign payload_len = udp_len_reg - 16'd8;
  // Index of the last IP header byte; a stale IHL of 0 after reset never matches byte 0.
  assign ip_end      = {10'd0, ihl_reg, 2'b00} - 16'd1;

  always_comb begin
    state_next     = state_reg;
    uc_ok_next     = uc_ok_reg;
    bc_ok_next     = bc_ok_reg;
    ihl_next       = ihl_reg;
    ip_hold_next   = ip_hold_reg;
    port_hold_next = port_hold_reg;
    udp_len_next   = udp_len_reg;
    rx_data_next   = rx_data_reg;
    rx_valid_next  = 1'b0;
    rx_done_next   = 1'b0;
    rx_error_next  = 1'b0;
    byte_num_next  = byte_num_reg;
    src_ip_next    = src_ip_reg;
    src_port_next  = src_port_reg;
    uc_hit         = 1'b0;
    bc_hit         = 1'b0;
    hdr_bad        = 1'b0;

    case (state_reg)
      IDLE: begin
        // A frame not starting with preamble is discarded whole.
        if (gmii_rx_dv) state_next = (gmii_rxd == 8'h55) ? PREAMBLE : DROP;
      end
      PREAMBLE: begin
        if (!gmii_rx_dv) state_next = IDLE;
        else if (gmii_rxd == 8'h55) state_next = PREAMBLE;
        else if (gmii_rxd == 8'hd5 && cnt_reg >= 16'd5) state_next = ETH_HEAD;
        else state_next = DROP;
      end
      ETH_HEAD: begin
        if (!gmii_rx_dv) state_next = IDLE;
        else begin
          if (cnt_reg < 16'd6) begin
            uc_hit     = (cnt_reg == 16'd0 || uc_ok_reg) && gmii_rxd == mac_bytes[cnt_reg[2:0]];
            bc_hit     = ACCEPT_BROADCAST && (cnt_reg == 16'd0 || bc_ok_reg) && gmii_rxd == 8'hff;
            uc_ok_next = uc_hit;
            bc_ok_next = bc_hit;
            hdr_bad    = !uc_hit && !bc_hit;
          end
          if (cnt_reg == 16'd12 && gmii_rxd != 8'h08) hdr_bad = 1'b1;
          if (cnt_reg == 16'd13 && gmii_rxd != 8'h00) hdr_bad = 1'b1;
          if (hdr_bad) state_next = DROP;
          else if (cnt_reg == 16'd13) state_next = IP_HEAD;
        end
      end
      IP_HEAD: begin
        if (!gmii_rx_dv) state_next = IDLE;
        else begin
          if (cnt_reg == 16'd0) begin
            ihl_next = gmii_rxd[3:0];
            hdr_bad  = gmii_rxd[7:4] != 4'h4 || gmii_rxd[3:0] < 4'd5;
          end
          if (cnt_reg == 16'd9 && gmii_rxd != 8'h11) hdr_bad = 1'b1;
          if (cnt_reg >= 16'd12 && cnt_reg <= 16'd15) ip_hold_next = {ip_hold_reg[23:0], gmii_rxd};
          if (cnt_reg >= 16'd16 && cnt_reg <= 16'd19 && gmii_rxd != ip_bytes[cnt_reg[1:0]])
            hdr_bad = 1'b1;
          if (hdr_bad) state_next = DROP;
          else if (cnt_reg == ip_end) state_next = UDP_HEAD;
        end
      end
      UDP_HEAD: begin
        if (!gmii_rx_dv) state_next = IDLE;
        else begin
          if (cnt_reg <= 16'd1) port_hold_next = {port_hold_reg[7:0], gmii_rxd};
          if ((cnt_reg == 16'd2 || cnt_reg == 16'd3) && gmii_rxd != port_bytes[cnt_reg[0]])
            hdr_bad = 1'b1;
          if (cnt_reg == 16'd4 || cnt_reg == 16'd5) udp_len_next = {udp_len_reg[7:0], gmii_rxd};
          if (hdr_bad) state_next = DROP;
          else if (cnt_reg == 16'd7) begin
            if (udp_len_reg < 16'd8 || payload_len > MAX_P) begin
              rx_error_next = 1'b1;
              state_next    = DROP;
            end else if (payload_len == 16'd0) begin
              rx_done_next = 1'b1;
              state_next   = DROP;
            end else begin
              byte_num_next = payload_len;
              src_ip_next   = ip_hold_reg;
              src_port_next = port_hold_reg;
              state_next    = RX_DATA;
            end
          end
        end
      end
      RX_DATA: begin
        if (!gmii_rx_dv) begin
          rx_error_next = 1'b1;
          state_next    = IDLE;
        end else begin
          rx_valid_next = 1'b1;
          rx_data_next  = gmii_rxd;
          if (cnt_reg == byte_num_reg - 16'd1) begin
            rx_done_next = 1'b1;
            state_next   = DROP;
          end
        end
      end
      DROP: begin
        if (!gmii_rx_dv) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    cnt_next = (state_next != state_reg) ? 16'd0 : cnt_reg + 16'd1;
  end

  always_ff @(posedge clk_125m or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      uc_ok_reg     <= 1'b0;
      bc_ok_reg     <= 1'b0;
      ihl_reg       <= '0;
      ip_hold_reg   <= '0;
      port_hold_reg <= '0;
      udp_len_reg   <= '0;
      rx_data_reg   <= '0;
      rx_valid_reg  <= 1'b0;
      rx_done_reg   <= 1'b0;
      rx_error_reg  <= 1'b0;
      byte_num_reg  <= '0;
      src_ip_reg    <= '0;
      src_port_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      uc_ok_reg     <= uc_ok_next;
      bc_ok_reg     <= bc_ok_next;
      ihl_reg       <= ihl_next;
      ip_hold_reg   <= ip_hold_next;
      port_hold_reg <= port_hold_next;
      udp_len_reg   <= udp_len_next;
      rx_data_reg   <= rx_data_next;
      rx_valid_reg  <= rx_valid_next;
      rx_done_reg   <= rx_done_next;
      rx_error_reg  <= rx_error_next;
      byte_num_reg  <= byte_num_next;
      src_ip_reg    <= src_ip_next;
      src_port_reg  <= src_port_next;
    end
  end

  assign rx_data       = rx_data_reg;
  assign rx_data_valid = rx_valid_reg;
  assign rx_done       = rx_done_reg;
  assign rx_error      = rx_error_reg;
  assign rx_byte_num   = byte_num_reg;
  assign rx_src_ip     = src_ip_reg;
  assign rx_src_port   = src_port_reg;

endmodule

// File: tb/tb_udp_receive.sv
// Bench for udp_receive: table of directed frames, hand sequences for back-to-back and
// reset, then random frames checked against a byte-level frame parser model.
module tb_udp_receive;

  typedef logic [7:0] u8;

  localparam logic [47:0] LMAC     = 48'h02_11_22_33_44_55;
  localparam logic [31:0] LIP      = 32'hc0a80002;
  localparam logic [15:0] LPORT    = 16'd6102;
  localparam logic [31:0] TB_SIP   = 32'hc0a80003;
  localparam logic [15:0] TB_SPORT = 16'd5000;
  localparam int          MAXP     = 1472;

  typedef struct {
    int mac_sel;            // 0 local, 1 broadcast, 2 wrong
    logic [15:0] etype;
    logic [31:0] dip;
    logic [15:0] dport;
    logic [31:0] sip;
    logic [15:0] sport;
    int ihl;
    int plen;
    int ulen;               // -1: plen+8
    int cut;                // -1: full frame; else payload bytes before dv drops
    bit pad;
    int n_pre;
    int eb, ed, ee;         // expected beats, done pulses, error pulses
  } vec_t;

  typedef struct {
    int done;
    int err;
    bit acc;
    logic [15:0] p;
    logic [31:0] sip;
    logic [15:0] sport;
  } res_t;

  logic        clk_125m = 1'b0;
  logic        reset_n;
  logic [47:0] local_mac;
  logic [31:0] local_ip;
  logic [15:0] local_port;
  logic [7:0]  gmii_rxd;
  logic        gmii_rx_dv;
  logic [7:0]  rx_data, rx_data_nb;
  logic        rx_data_valid, rx_data_valid_nb;
  logic        rx_done, rx_done_nb;
  logic        rx_error, rx_error_nb;
  logic [15:0] rx_byte_num, rx_byte_num_nb;
  logic [31:0] rx_src_ip, rx_src_ip_nb;
  logic [15:0] rx_src_port, rx_src_port_nb;

  always #4 clk_125m = ~clk_125m;

  udp_receive #(.ACCEPT_BROADCAST(1'b1), .MAX_PAYLOAD(MAXP)) dut (
    .clk_125m(clk_125m), .reset_n(reset_n), .local_mac(local_mac), .local_ip(local_ip),
    .local_port(local_port), .gmii_rxd(gmii_rxd), .gmii_rx_dv(gmii_rx_dv),
    .rx_data(rx_data), .rx_data_valid(rx_data_valid), .rx_done(rx_done), .rx_error(rx_error),
    .rx_byte_num(rx_byte_num), .rx_src_ip(rx_src_ip), .rx_src_port(rx_src_port));

  udp_receive #(.ACCEPT_BROADCAST(1'b0), .MAX_PAYLOAD(MAXP)) dut_nb (
    .clk_125m(clk_125m), .reset_n(reset_n), .local_mac(local_mac), .local_ip(local_ip),
    .local_port(local_port), .gmii_rxd(gmii_rxd), .gmii_rx_dv(gmii_rx_dv),
    .rx_data(rx_data_nb), .rx_data_valid(rx_data_valid_nb), .rx_done(rx_done_nb),
    .rx_error(rx_error_nb), .rx_byte_num(rx_byte_num_nb), .rx_src_ip(rx_src_ip_nb),
    .rx_src_port(rx_src_port_nb));

  // Output monitor, sampled on the falling edge.
  u8  got_q[$];
  int done_cnt = 0, err_cnt = 0, dnv_cnt = 0, both_cnt = 0, nb_cnt = 0;
  always @(negedge clk_125m) begin
    if (rx_data_valid) got_q.push_back(rx_data);
    if (rx_done) done_cnt++;
    if (rx_error) err_cnt++;
    if (rx_done && !rx_data_valid) dnv_cnt++;
    if (rx_done && rx_error) both_cnt++;
    if (rx_data_valid_nb) nb_cnt++;
  end

  int total = 0, bad = 0;
  int s_idx, s_done, s_err, s_dnv, s_both, s_nb;
  logic [15:0] h_bn;
  logic [31:0] h_ip;
  logic [15:0] h_port;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic snap();
    s_idx = got_q.size(); s_done = done_cnt; s_err = err_cnt;
    s_dnv = dnv_cnt; s_both = both_cnt; s_nb = nb_cnt;
  endtask

  task automatic verify(input string tag, input u8 epay[$], input int edone, input int eerr,
                        input int enb);
    int nbeats, mism;
    nbeats = got_q.size() - s_idx;
    mism = 0;
    for (int k = 0; k < epay.size() && k < nbeats; k++)
      if (got_q[s_idx+k] !== epay[k]) mism++;
    chk({tag, " beats"}, 64'(nbeats), 64'(epay.size()));
    chk({tag, " data_mismatches"}, 64'(mism), 64'd0);
    chk({tag, " done"}, 64'(done_cnt - s_done), 64'(edone));
    chk({tag, " error"}, 64'(err_cnt - s_err), 64'(eerr));
    chk({tag, " nobcast_beats"}, 64'(nb_cnt - s_nb), 64'(enb));
    chk({tag, " done_without_data"}, 64'(dnv_cnt - s_dnv), 64'((epay.size() == 0) ? edone : 0));
    chk({tag, " done_and_error"}, 64'(both_cnt - s_both), 64'd0);
    chk({tag, " byte_num"}, 64'(rx_byte_num), 64'(h_bn));
    chk({tag, " src_ip"}, 64'(rx_src_ip), 64'(h_ip));
    chk({tag, " src_port"}, 64'(rx_src_port), 64'(h_port));
    $display("%s: beats=%0d done=%0d err=%0d byte_num=%0d", tag, nbeats,
             done_cnt - s_done, err_cnt - s_err, rx_byte_num);
  endtask

  function automatic vec_t mk(int mac_sel, int etype, bit dip_ok, bit dport_ok, int ihl,
                              int plen, int ulen, int cut, bit pad, int n_pre,
                              int eb, int ed, int ee);
    vec_t v;
    v.mac_sel = mac_sel; v.etype = 16'(etype);
    v.dip = dip_ok ? LIP : (LIP ^ 32'h1);
    v.dport = dport_ok ? LPORT : (LPORT ^ 16'h1);
    v.sip = TB_SIP; v.sport = TB_SPORT;
    v.ihl = ihl; v.plen = plen; v.ulen = ulen; v.cut = cut; v.pad = pad; v.n_pre = n_pre;
    v.eb = eb; v.ed = ed; v.ee = ee;
    return v;
  endfunction

  function automatic void build(input vec_t v, input u8 pay[$], output u8 f[$]);
    u8 b;
    logic [15:0] w;
    f = {};
    repeat (v.n_pre) f.push_back(8'h55);
    f.push_back(8'hd5);
    for (int k = 0; k < 6; k++) begin
      b = LMAC[47-8*k -: 8];
      if (v.mac_sel == 1) b = 8'hff;
      if (v.mac_sel == 2 && k == 5) b = b ^ 8'h01;
      f.push_back(b);
    end
    f.push_back(8'h02);
    repeat (5) f.push_back(8'h09);
    f.push_back(v.etype[15:8]); f.push_back(v.etype[7:0]);
    f.push_back({4'h4, v.ihl[3:0]}); f.push_back(8'h00);
    w = 16'(v.ihl * 4 + 8 + v.plen);
    f.push_back(w[15:8]); f.push_back(w[7:0]);
    f.push_back(8'h00); f.push_back(8'h00); f.push_back(8'h40); f.push_back(8'h00);
    f.push_back(8'h40); f.push_back(8'h11); f.push_back(8'h00); f.push_back(8'h00);
    for (int k = 0; k < 4; k++) f.push_back(v.sip[31-8*k -: 8]);
    for (int k = 0; k < 4; k++) f.push_back(v.dip[31-8*k -: 8]);
    for (int k = 0; k < (v.ihl - 5) * 4; k++) f.push_back(8'ha5);
    f.push_back(v.sport[15:8]); f.push_back(v.sport[7:0]);
    f.push_back(v.dport[15:8]); f.push_back(v.dport[7:0]);
    w = (v.ulen < 0) ? 16'(v.plen + 8) : 16'(v.ulen);
    f.push_back(w[15:8]); f.push_back(w[7:0]);
    f.push_back(8'h00); f.push_back(8'h00);
    for (int k = 0; k < v.plen; k++) begin
      if (v.cut >= 0 && k >= v.cut) break;
      f.push_back(pay[k]);
    end
    if (v.cut < 0) begin
      if (v.pad) while (f.size() < v.n_pre + 1 + 60) f.push_back(8'h00);
      repeat (4) f.push_back(8'($urandom));
    end
  endfunction

  // Reference: parse a whole frame as a byte array and decide what the receiver delivers.
  function automatic void ref_model(input u8 f[$], input bit bc_en, output u8 pay[$],
                                    output res_t r);
    int n, i, e, ip, u, ihl, avail;
    logic [15:0] len, p;
    bit uc, bc;
    r = '{default: 0};
    pay = {};
    n = f.size();
    i = 0;
    while (i < n && f[i] == 8'h55) i++;
    if (i < 6 || i >= n || f[i] != 8'hd5) return;
    e = i + 1;
    if (n < e + 14) return;
    uc = 1'b1; bc = bc_en;
    for (int k = 0; k < 6; k++) begin
      if (f[e+k] != LMAC[47-8*k -: 8]) uc = 1'b0;
      if (f[e+k] != 8'hff) bc = 1'b0;
    end
    if (!(uc || bc) || f[e+12] != 8'h08 || f[e+13] != 8'h00) return;
    ip = e + 14;
    if (n < ip + 20) return;
    ihl = int'(f[ip][3:0]);
    if (f[ip][7:4] != 4'h4 || ihl < 5 || f[ip+9] != 8'h11) return;
    if ({f[ip+16], f[ip+17], f[ip+18], f[ip+19]} != LIP) return;
    u = ip + ihl * 4;
    if (n < u + 8) return;
    if ({f[u+2], f[u+3]} != LPORT) return;
    len = {f[u+4], f[u+5]};
    if (len < 16'd8 || int'(len) - 8 > MAXP) begin
      r.err = 1;
      return;
    end
    p = len - 16'd8;
    if (p == 16'd0) begin
      r.done = 1;
      return;
    end
    r.acc = 1'b1; r.p = p;
    r.sip = {f[ip+12], f[ip+13], f[ip+14], f[ip+15]};
    r.sport = {f[u], f[u+1]};
    avail = n - (u + 8);
    for (int k = 0; k < int'(p) && k < avail; k++) pay.push_back(f[u+8+k]);
    if (avail < int'(p)) r.err = 1; else r.done = 1;
  endfunction

  task automatic send(input u8 f[$], input int gap);
    foreach (f[k]) begin
      @(negedge clk_125m);
      gmii_rx_dv = 1'b1;
      gmii_rxd = f[k];
    end
    @(negedge clk_125m);
    gmii_rx_dv = 1'b0;
    gmii_rxd = 8'h00;
    repeat (gap - 1) @(negedge clk_125m);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[$];
    vec_t v;
    u8 pay[$], f[$], epay[$], epay2[$], f2[$], nbpay[$];
    res_t r, rnb;

    local_mac = LMAC; local_ip = LIP; local_port = LPORT;
    gmii_rxd = 8'h00; gmii_rx_dv = 1'b0; reset_n = 1'b0;
    h_bn = '0; h_ip = '0; h_port = '0;

    tbl.push_back(mk(0, 'h0800, 1, 1, 5, 4, -1, -1, 0, 7, 4, 1, 0));      // unicast
    tbl.push_back(mk(2, 'h0800, 1, 1, 5, 4, -1, -1, 0, 7, 0, 0, 0));      // wrong MAC
    tbl.push_back(mk(0, 'h0800, 0, 1, 5, 4, -1, -1, 0, 7, 0, 0, 0));      // wrong IP
    tbl.push_back(mk(0, 'h0800, 1, 0, 5, 4, -1, -1, 0, 7, 0, 0, 0));      // wrong port
    tbl.push_back(mk(0, 'h0806, 1, 1, 5, 4, -1, -1, 0, 7, 0, 0, 0));      // ARP ethertype
    tbl.push_back(mk(1, 'h0800, 1, 1, 5, 4, -1, -1, 0, 7, 4, 1, 0));      // broadcast
    tbl.push_back(mk(0, 'h0800, 1, 1, 5, 18, -1, -1, 1, 7, 18, 1, 0));    // 60-B frame
    tbl.push_back(mk(0, 'h0800, 1, 1, 5, 6, -1, -1, 1, 7, 6, 1, 0));      // padded short
    tbl.push_back(mk(0, 'h0800, 1, 1, 5, 100, -1, 10, 0, 7, 10, 0, 1));   // truncated
    tbl.push_back(mk(0, 'h0800, 1, 1, 5, 4, -1, -1, 0, 7, 4, 1, 0));      // recovery
    tbl.push_back(mk(0, 'h0800, 1, 1, 6, 8, -1, -1, 0, 7, 8, 1, 0));      // IHL=6
    tbl.push_back(mk(0, 'h0800, 1, 1, 5, 4, 7, -1, 0, 7, 0, 0, 1));       // L=7
    tbl.push_back(mk(0, 'h0800, 1, 1, 5, 4, 1481, -1, 0, 7, 0, 0, 1));    // L=1481
    tbl.push_back(mk(0, 'h0800, 1, 1, 5, 0, -1, -1, 1, 7, 0, 1, 0));      // empty payload
    tbl.push_back(mk(0, 'h0800, 1, 1, 5, 1472, -1, -1, 0, 7, 1472, 1, 0)); // max payload
    tbl.push_back(mk(0, 'h0800, 1, 1, 5, 4, -1, -1, 0, 5, 0, 0, 0));      // 5 preamble bytes
    tbl.push_back(mk(0, 'h0800, 1, 1, 5, 3, -1, -1, 0, 6, 3, 1, 0));      // 6 preamble bytes

    repeat (3) @(negedge clk_125m);
    chk("reset rx_data_valid", 64'(rx_data_valid), 64'd0);
    chk("reset rx_done", 64'(rx_done), 64'd0);
    chk("reset rx_error", 64'(rx_error), 64'd0);
    chk("reset rx_data", 64'(rx_data), 64'd0);
    chk("reset rx_byte_num", 64'(rx_byte_num), 64'd0);
    chk("reset rx_src_ip", 64'(rx_src_ip), 64'd0);
    chk("reset rx_src_port", 64'(rx_src_port), 64'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk_125m);

    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      pay = {};
      for (int k = 0; k < v.plen; k++) pay.push_back(8'(k + 1));
      build(v, pay, f);
      epay = {};
      for (int k = 0; k < v.eb; k++) epay.push_back(pay[k]);
      if (v.eb > 0) begin
        h_bn = 16'(v.plen); h_ip = v.sip; h_port = v.sport;
      end
      snap();
      send(f, 6);
      verify($sformatf("row%0d", i), epay, v.ed, v.ee, (v.mac_sel == 1) ? 0 : v.eb);
    end

    // Two frames separated by a single idle cycle.
    v = mk(0, 'h0800, 1, 1, 5, 4, -1, -1, 0, 7, 0, 0, 0);
    pay = {8'h11, 8'h22, 8'h33, 8'h44};
    build(v, pay, f);
    epay = pay;
    v.plen = 5; v.sport = 16'h0abc;
    pay = {8'h55, 8'h66, 8'h77, 8'h88, 8'h99};
    build(v, pay, f2);
    epay = {epay, pay};
    h_bn = 16'd5; h_ip = v.sip; h_port = 16'h0abc;
    snap();
    send(f, 1);
    send(f2, 6);
    verify("back_to_back", epay, 2, 0, 9);

    // Reset asserted in the middle of a payload.
    v = mk(0, 'h0800, 1, 1, 5, 50, -1, -1, 0, 7, 0, 0, 0);
    v.sip = 32'h0a000001;
    pay = {};
    for (int k = 0; k < 50; k++) pay.push_back(8'(k));
    build(v, pay, f);
    for (int k = 0; k < 8 + 42 + 20; k++) begin
      @(negedge clk_125m);
      gmii_rx_dv = 1'b1;
      gmii_rxd = f[k];
    end
    @(negedge clk_125m);
    chk("midpayload rx_data_valid", 64'(rx_data_valid), 64'd1);
    chk("midpayload rx_src_ip", 64'(rx_src_ip), 64'h0a000001);
    reset_n = 1'b0;
    #1;
    chk("async reset rx_data_valid", 64'(rx_data_valid), 64'd0);
    chk("async reset rx_data", 64'(rx_data), 64'd0);
    chk("async reset rx_byte_num", 64'(rx_byte_num), 64'd0);
    chk("async reset rx_src_ip", 64'(rx_src_ip), 64'd0);
    chk("async reset rx_src_port", 64'(rx_src_port), 64'd0);
    gmii_rx_dv = 1'b0;
    gmii_rxd = 8'h00;
    repeat (2) @(negedge clk_125m);
    reset_n = 1'b1;
    h_bn = '0; h_ip = '0; h_port = '0;
    repeat (2) @(negedge clk_125m);
    v = mk(0, 'h0800, 1, 1, 5, 4, -1, -1, 0, 7, 0, 0, 0);
    pay = {8'h01, 8'h02, 8'h03, 8'h04};
    build(v, pay, f);
    h_bn = 16'd4; h_ip = TB_SIP; h_port = TB_SPORT;
    snap();
    send(f, 6);
    verify("after_reset", pay, 1, 0, 4);

    // Random frames against the parser model.
    for (int i = 0; i < 150; i++) begin
      int rs;
      rs = $urandom_range(0, 19);
      v = mk(0, 'h0800, 1, 1, 5, 0, -1, -1, 0, 7, 0, 0, 0);
      v.mac_sel = (rs < 14) ? 0 : (rs < 17) ? 1 : 2;
      if ($urandom_range(0, 19) == 0) v.etype = 16'h0806;
      if ($urandom_range(0, 14) == 0) v.dip = 32'($urandom);
      if ($urandom_range(0, 14) == 0) v.dport = 16'($urandom);
      v.sip = 32'($urandom);
      v.sport = 16'($urandom);
      v.ihl = $urandom_range(5, 7);
      v.plen = $urandom_range(0, 40);
      if ($urandom_range(0, 9) == 0) v.ulen = $urandom_range(0, 60);
      if ($urandom_range(0, 5) == 0) v.cut = $urandom_range(0, v.plen);
      v.pad = 1'($urandom_range(0, 1));
      v.n_pre = $urandom_range(5, 8);
      pay = {};
      for (int k = 0; k < v.plen; k++) pay.push_back(8'($urandom));
      build(v, pay, f);
      ref_model(f, 1'b1, epay, r);
      ref_model(f, 1'b0, nbpay, rnb);
      if (r.acc) begin
        h_bn = r.p; h_ip = r.sip; h_port = r.sport;
      end
      epay2 = epay;
      snap();
      send(f, 6);
      verify($sformatf("rand%0d", i), epay2, r.done, r.err, nbpay.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
